// File: rtl/gpu_pkg.sv
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared encodings for the gpu_core_mc micro-core: opcodes,
//                predicate codes, FSM states and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_pkg;

  // Opcode field instr[28:24]; unlisted values execute as NOP.
  typedef enum logic [4:0] {
    OP_LD     = 5'd0,
    OP_ST     = 5'd1,
    OP_MUL    = 5'd2,
    OP_ADD    = 5'd3,
    OP_SUB    = 5'd4,
    OP_SRL    = 5'd5,
    OP_SLL    = 5'd6,
    OP_AND    = 5'd7,
    OP_OR     = 5'd8,
    OP_XOR    = 5'd9,
    OP_LDI    = 5'd10,
    OP_CMP    = 5'd11,
    OP_QPUSHI = 5'd15,
    OP_QPUSHR = 5'd16,
    OP_END    = 5'd17
  } opcode_e;

  // Predicate field instr[31:30].
  typedef enum logic [1:0] {
    PRED_AL = 2'd0,
    PRED_Z  = 2'd1,
    PRED_NZ = 2'd2,
    PRED_N  = 2'd3
  } pred_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_Q_WAIT   = 3'd5,
    ST_HALT     = 3'd6
  } state_e;

  // True when the predicate allows the instruction to take effect.
  function automatic logic pred_pass(input logic [1:0] pred,
                                     input logic z, input logic n);
    logic ok;
    case (pred)
      PRED_AL: ok = 1'b1;
      PRED_Z:  ok = z;
      PRED_NZ: ok = ~z;
      default: ok = n;
    endcase
    return ok;
  endfunction

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_q_op(input logic [4:0] op);
    return (op == OP_QPUSHI) || (op == OP_QPUSHR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpu_alu.sv
// ============================================================================
//  Module      : gpu_alu
//  Description : Combinational ALU for gpu_core_mc. Results are truncated to
//                DATA_W; shift amounts are taken modulo DATA_W; MUL keeps the
//                low DATA_W bits. CMP computes A-B (result used for flags).
//  Ports       : op     in  5       opcode
//                a, b   in  DATA_W  operands
//                result out DATA_W  ALU result
//                zero   out 1       result == 0
//                neg    out 1       result MSB
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_alu
  import gpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              neg
);

  localparam logic [DATA_W-1:0] DW = DATA_W'(DATA_W);

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   shamt;
  logic [DATA_W-1:0]   prod_unused_hi;

  always_comb begin
    prod           = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    prod_unused_hi = prod[2*DATA_W-1:DATA_W];
    shamt          = b % DW;
    case (op)
      OP_MUL:  result = prod[DATA_W-1:0];
      OP_ADD:  result = a + b;
      OP_SUB,
      OP_CMP:  result = a - b;
      OP_SRL:  result = a >> shamt;
      OP_SLL:  result = a << shamt;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
    zero = (result == '0);
    neg  = result[DATA_W-1];
  end

endmodule

`default_nettype wire

// File: rtl/gpu_core_mc.sv
// ============================================================================
//  Module      : gpu_core_mc
//  Description : Multi-cycle predicated micro-core. Each instruction walks
//                FETCH -> DECODE -> EXEC, with LD/ST parking in MEM_WAIT and
//                queue pushes parking in Q_WAIT until their handshakes land.
//                The register file is external (combinational reads).
//  Ports       : clk, rst                  clock / sync active-high reset
//                start, start_pc           launch from IDLE or HALT
//                pc, instr                 instruction fetch
//                rf_raddr0/1, rf_rdata0/1  register reads
//                rf_wen/waddr/wdata        register write pulse
//                mem_req/we/addr/wdata     data-memory request
//                mem_ack, mem_rdata        data-memory completion
//                q_valid/id/data, q_ready  work-queue push
//                busy, halted              status
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_core_mc
  import gpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 16,
  parameter int NQ     = 4,
  localparam int RA_W  = $clog2(NREGS),
  localparam int QID_W = $clog2(NQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  output logic [RA_W-1:0]   rf_raddr0,
  output logic [RA_W-1:0]   rf_raddr1,
  input  logic [DATA_W-1:0] rf_rdata0,
  input  logic [DATA_W-1:0] rf_rdata1,
  output logic              rf_wen,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              q_valid,
  output logic [QID_W-1:0]  q_id,
  output logic [DATA_W-1:0] q_data,
  input  logic              q_ready,
  output logic              busy,
  output logic              halted
);

  state_e state, state_n;
  logic [ADDR_W-1:0] pc_n, pc_inc;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic              flag_z, flag_n, flag_z_n, flag_n_n;
  logic              halted_n;

  // Decode of the latched instruction word
  logic [1:0]        pred;
  logic              optype;
  logic [4:0]        op;
  logic [RA_W-1:0]   rd;
  logic [11:0]       imm;
  logic [DATA_W-1:0] imm_ext, opnd_b;
  logic              pred_ok, do_mem, do_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_n;

  assign pred      = instr_q[31:30];
  assign optype    = instr_q[29];
  assign op        = instr_q[28:24];
  assign rf_raddr0 = instr_q[20 +: RA_W];
  assign rf_raddr1 = instr_q[16 +: RA_W];
  assign rd        = instr_q[12 +: RA_W];
  assign imm       = instr_q[11:0];
  assign imm_ext   = DATA_W'(imm);
  assign opnd_b    = optype ? imm_ext : opb_q;
  assign pred_ok   = pred_pass(pred, flag_z, flag_n);
  assign pc_inc    = pc + 1'b1;

  // Handshake phases cover the issuing EXEC cycle as well as the wait
  // state, so a same-cycle ack/ready completes without visiting it.
  assign do_mem = ((state == ST_EXEC) && pred_ok && is_mem_op(op)) ||
                  (state == ST_MEM_WAIT);
  assign do_q   = ((state == ST_EXEC) && pred_ok && is_q_op(op)) ||
                  (state == ST_Q_WAIT);

  assign busy = (state != ST_IDLE) && (state != ST_HALT);

  gpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (opa_q),
    .b      (opnd_b),
    .result (alu_res),
    .zero   (alu_z),
    .neg    (alu_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      instr_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      flag_z <= flag_z_n;
      flag_n <= flag_n_n;
      halted <= halted_n;
      if (state == ST_FETCH) begin
        instr_q <= instr;
      end
      if (state == ST_DECODE) begin
        opa_q <= rf_rdata0;
        opb_q <= rf_rdata1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    flag_z_n  = flag_z;
    flag_n_n  = flag_n;
    halted_n  = halted;
    rf_wen    = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    q_valid   = 1'b0;
    q_id      = '0;
    q_data    = '0;

    // All request fields come from latched state, so they stay stable
    // for the whole wait.
    if (do_mem) begin
      mem_req = 1'b1;
      if (op == OP_ST) begin
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(opnd_b);
        mem_wdata = opa_q;
      end else begin
        mem_addr  = ADDR_W'(opa_q);
      end
      if (mem_ack) begin
        if (op == OP_LD) begin
          rf_wen   = 1'b1;
          rf_waddr = rd;
          rf_wdata = mem_rdata;
        end
        state_n = ST_FETCH;
        pc_n    = pc_inc;
      end else begin
        state_n = ST_MEM_WAIT;
      end
    end

    if (do_q) begin
      q_valid = 1'b1;
      q_id    = (op == OP_QPUSHI) ? imm[QID_W-1:0] : opnd_b[QID_W-1:0];
      q_data  = opa_q;
      if (q_ready) begin
        state_n = ST_FETCH;
        pc_n    = pc_inc;
      end else begin
        state_n = ST_Q_WAIT;
      end
    end

    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_n  = ST_FETCH;
          pc_n     = start_pc;
          halted_n = 1'b0;
        end
      end
      ST_FETCH:  state_n = ST_DECODE;
      ST_DECODE: state_n = ST_EXEC;
      ST_EXEC: begin
        if (!pred_ok) begin
          state_n = ST_FETCH;
          pc_n    = pc_inc;
        end else if (!do_mem && !do_q) begin
          state_n = ST_FETCH;
          pc_n    = pc_inc;
          case (op)
            OP_MUL, OP_ADD, OP_SUB, OP_SRL, OP_SLL,
            OP_AND, OP_OR, OP_XOR: begin
              rf_wen   = 1'b1;
              rf_waddr = rd;
              rf_wdata = alu_res;
              flag_z_n = alu_z;
              flag_n_n = alu_n;
            end
            OP_LDI: begin
              rf_wen   = 1'b1;
              rf_waddr = rd;
              rf_wdata = imm_ext;
            end
            OP_CMP: begin
              flag_z_n = alu_z;
              flag_n_n = alu_n;
            end
            OP_END: begin
              state_n  = ST_HALT;
              pc_n     = pc;
              halted_n = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_MEM_WAIT, ST_Q_WAIT: ;
      default: state_n = ST_IDLE;
    endcase

    // Reset is sampled at the edge; suppress strobes in the reset cycle so
    // an abandoned transaction cannot complete its write.
    if (rst) begin
      rf_wen    = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      q_valid   = 1'b0;
      q_id      = '0;
      q_data    = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpu_core_mc.sv
// ============================================================================
//  Module      : tb_gpu_core_mc
//  Description : Self-checking bench for gpu_core_mc. Expected register
//                writes, memory requests and queue pushes are queued when the
//                program is loaded and compared as the core produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpu_core_mc;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] start_pc, pc;
  logic [31:0] instr;
  logic [3:0]  rf_raddr0, rf_raddr1, rf_waddr;
  logic [15:0] rf_rdata0, rf_rdata1, rf_wdata;
  logic        rf_wen, mem_req, mem_we, mem_ack, q_valid, q_ready, busy, halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, q_data;
  logic [1:0]  q_id;

  always #5 clk = ~clk;

  gpu_core_mc dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .pc(pc),
    .instr(instr), .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .q_valid(q_valid), .q_id(q_id),
    .q_data(q_data), .q_ready(q_ready), .busy(busy), .halted(halted)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- environment: imem, register file, memory, queue ------
  logic [31:0] imem [256];
  logic [15:0] rf   [16];
  int          ack_delay;
  int          mem_cnt, q_cnt;

  assign instr     = imem[pc[7:0]];
  assign rf_rdata0 = rf[rf_raddr0];
  assign rf_rdata1 = rf[rf_raddr1];

  always @(posedge clk) if (rf_wen) rf[rf_waddr] <= rf_wdata;

  always_comb begin
    mem_ack   = mem_req && (mem_cnt >= ((mem_addr == 16'h0040) ? ack_delay : 0));
    mem_rdata = mem_ack ? 16'hBEEF : 16'h0000;
    q_ready   = q_valid && (q_cnt >= 3);
  end

  always @(posedge clk) begin
    mem_cnt <= (mem_req && !mem_ack && !rst) ? mem_cnt + 1 : 0;
    q_cnt   <= (q_valid && !q_ready && !rst) ? q_cnt + 1 : 0;
  end

  function automatic logic [31:0] mk(input logic [1:0] p, input logic o,
                                     input logic [4:0] op, input logic [3:0] s0,
                                     input logic [3:0] s1, input logic [3:0] d,
                                     input logic [11:0] imm);
    return {p, o, op, s0, s1, d, imm};
  endfunction

  // ---------------- scoreboard ---------------------------------------------
  typedef struct { logic [3:0] addr; logic [15:0] data; } wr_exp_t;
  typedef struct { logic [15:0] addr; logic we; logic [15:0] wdata; int len; } mem_exp_t;
  typedef struct { logic [1:0] id; logic [15:0] data; int len; } q_exp_t;

  wr_exp_t  wr_q[$];
  mem_exp_t mem_q[$];
  q_exp_t   qp_q[$];

  mem_exp_t cur_mem;
  q_exp_t   cur_q;
  logic     mem_active = 1'b0, q_active = 1'b0;
  int       mem_len = 0, q_len = 0, n_q_acc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wen) begin
        if (wr_q.size() == 0) check_eq("rf_wen_unexpected", 1, 0);
        else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          check_eq("rf_waddr", {28'd0, rf_waddr}, {28'd0, w.addr});
          check_eq("rf_wdata", {16'd0, rf_wdata}, {16'd0, w.data});
        end
      end
      if (mem_req) begin
        if (!mem_active) begin
          if (mem_q.size() == 0) begin
            check_eq("mem_req_unexpected", 1, 0);
            cur_mem = '{16'h0, 1'b0, 16'h0, 0};
          end else cur_mem = mem_q.pop_front();
          mem_active = 1'b1;
          mem_len    = 0;
        end
        mem_len++;
        check_eq("mem_addr", {16'd0, mem_addr}, {16'd0, cur_mem.addr});
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, cur_mem.we});
        check_eq("mem_wdata", {16'd0, mem_wdata}, {16'd0, cur_mem.wdata});
        if (mem_ack) begin
          check_eq("mem_len", mem_len, cur_mem.len);
          mem_active = 1'b0;
        end
      end else mem_active = 1'b0;
      if (q_valid) begin
        if (!q_active) begin
          if (qp_q.size() == 0) begin
            check_eq("q_push_unexpected", 1, 0);
            cur_q = '{2'd0, 16'h0, 0};
          end else cur_q = qp_q.pop_front();
          q_active = 1'b1;
          q_len    = 0;
        end
        q_len++;
        check_eq("q_id", {30'd0, q_id}, {30'd0, cur_q.id});
        check_eq("q_data", {16'd0, q_data}, {16'd0, cur_q.data});
        if (q_ready) begin
          check_eq("q_len", q_len, cur_q.len);
          n_q_acc++;
          q_active = 1'b0;
        end
      end else q_active = 1'b0;
    end
  end

  // ---------------- stimulus -------------------------------------------------
  task automatic load_prog();
    for (int i = 0; i < 256; i++) imem[i] = mk(2'd0, 1'b0, 5'd20, 4'd0, 4'd0, 4'd0, 12'd0);
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    rf[1] = 16'd5; rf[2] = 16'd7; rf[5] = 16'h0040;

    imem[8'h10] = mk(0, 0, 5'd3, 1, 2, 3, 0);        wr_q.push_back('{4'd3, 16'd12});
    imem[8'h11] = mk(0, 0, 5'd0, 5, 0, 4, 0);
    mem_q.push_back('{16'h0040, 1'b0, 16'h0000, 5}); wr_q.push_back('{4'd4, 16'hBEEF});
    imem[8'h12] = mk(0, 0, 5'd1, 4, 3, 0, 0);
    mem_q.push_back('{16'd12, 1'b1, 16'hBEEF, 1});
    imem[8'h13] = mk(0, 0, 5'd11, 1, 1, 0, 0);
    imem[8'h14] = mk(2, 0, 5'd3, 1, 2, 6, 0);
    imem[8'h15] = mk(1, 0, 5'd3, 1, 2, 7, 0);        wr_q.push_back('{4'd7, 16'd12});
    imem[8'h16] = mk(0, 1, 5'd15, 3, 0, 0, 12'd2);   qp_q.push_back('{2'd2, 16'd12, 4});
    imem[8'h17] = mk(0, 1, 5'd6, 4, 0, 9, 12'd17);   wr_q.push_back('{4'd9, 16'h7DDE});
    imem[8'h18] = mk(0, 1, 5'd10, 0, 0, 10, 12'h100); wr_q.push_back('{4'd10, 16'h0100});
    imem[8'h19] = mk(0, 0, 5'd2, 10, 10, 11, 0);     wr_q.push_back('{4'd11, 16'h0000});
    imem[8'h1A] = mk(1, 1, 5'd10, 0, 0, 12, 12'h55); wr_q.push_back('{4'd12, 16'h0055});
    imem[8'h1B] = mk(0, 0, 5'd4, 1, 2, 13, 0);       wr_q.push_back('{4'd13, 16'hFFFE});
    imem[8'h1C] = mk(3, 1, 5'd9, 1, 0, 14, 12'hF);   wr_q.push_back('{4'd14, 16'd10});
    imem[8'h1D] = mk(2, 1, 5'd5, 4, 0, 15, 12'd4);   wr_q.push_back('{4'd15, 16'h0BEE});
    imem[8'h1E] = mk(0, 0, 5'd16, 2, 1, 0, 0);       qp_q.push_back('{2'd1, 16'd7, 4});
    imem[8'h1F] = mk(0, 0, 5'd17, 0, 0, 0, 0);
    imem[8'h30] = mk(0, 0, 5'd0, 5, 0, 1, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_pc = 16'h0; ack_delay = 4;
    load_prog();
    repeat (3) @(negedge clk);
    check_eq("rst_pc", {16'd0, pc}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_halted", {31'd0, halted}, 0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 0);
    check_eq("rst_q_valid", {31'd0, q_valid}, 0);
    check_eq("rst_rf_wen", {31'd0, rf_wen}, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", {31'd0, busy}, 0);
    #1 start = 1'b1; start_pc = 16'h0010;
    @(negedge clk);
    check_eq("fetch_pc", {16'd0, pc}, 32'h10);
    check_eq("fetch_busy", {31'd0, busy}, 1);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("add_cyc3_wen", {31'd0, rf_wen}, 1);
    @(negedge clk);
    check_eq("add_next_pc", {16'd0, pc}, 32'h11);

    for (int i = 0; i < 2000 && !halted; i++) @(negedge clk);
    check_eq("halt_reached", {31'd0, halted}, 1);
    check_eq("halt_busy", {31'd0, busy}, 0);
    check_eq("halt_pc", {16'd0, pc}, 32'h1F);
    repeat (10) @(negedge clk);
    check_eq("halt_sticky", {31'd0, halted}, 1);
    check_eq("wr_left", wr_q.size(), 0);
    check_eq("mem_left", mem_q.size(), 0);
    check_eq("q_left", qp_q.size(), 0);
    check_eq("q_accepts", n_q_acc, 2);

    // Restart from HALT, then reset in the middle of a stalled load.
    ack_delay = 1000;
    mem_q.push_back('{16'h0040, 1'b0, 16'h0000, 0});
    #1 start = 1'b1; start_pc = 16'h0030;
    @(negedge clk);
    check_eq("restart_halted", {31'd0, halted}, 0);
    check_eq("restart_pc", {16'd0, pc}, 32'h30);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mw_req", {31'd0, mem_req}, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("mw_rst_req", {31'd0, mem_req}, 0);
    check_eq("mw_rst_busy", {31'd0, busy}, 0);
    check_eq("mw_rst_pc", {16'd0, pc}, 0);
    check_eq("mw_rst_wen", {31'd0, rf_wen}, 0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_req", {31'd0, mem_req}, 0);
    check_eq("post_rst_busy", {31'd0, busy}, 0);
    check_eq("post_rst_r1", {16'd0, rf[1]}, 5);
    check_eq("post_rst_mem_left", mem_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/gpu_core_mc.md
GPU_CORE_MC -- requirements
Module: gpu_core_mc

Interface
REQ-001 Parameter DATA_W, 16, datapath, register and memory word width.
REQ-002 Parameter NREGS, 16, register count; RA_W = $clog2(NREGS), at most 4.
REQ-003 Parameter ADDR_W, 16, PC and data-memory address width.
REQ-004 Parameter NQ, 4, work-queue count; QID_W = $clog2(NQ).
REQ-005 Single clock clk; reset rst is synchronous and active-high.
REQ-006 clk  in  1  core clock, all state updates on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  leave IDLE and begin fetching at start_pc.
REQ-009 start_pc  in  ADDR_W  first instruction address, sampled with start.
REQ-010 pc  out  ADDR_W  instruction address; instr is valid combinationally.
REQ-011 instr  in  32  instruction word at pc.
REQ-012 rf_raddr0 / rf_raddr1  out  RA_W  register read addresses.
REQ-013 rf_rdata0 / rf_rdata1  in  DATA_W  combinational register read data.
REQ-014 rf_wen / rf_waddr / rf_wdata  out  1 / RA_W / DATA_W  register write, one-cycle pulse.
REQ-015 mem_req / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_W / DATA_W  data-memory request.
REQ-016 mem_ack / mem_rdata  in  1 / DATA_W  request completion; rdata valid with ack.
REQ-017 q_valid / q_id / q_data  out  1 / QID_W / DATA_W  work-queue push.
REQ-018 q_ready  in  1  queue accepts push when high with q_valid.
REQ-019 busy / halted  out  1 / 1  executing / END retired.

Function
REQ-020 Decode: pred=instr[31:30], optype=instr[29], opcode=instr[28:24], rs0=[23:20], rs1=[19:16], rd=[15:12], imm=[11:0]; register fields truncated to RA_W.
REQ-021 Operand B = rf_rdata1 when optype=0, else imm zero-extended to DATA_W.
REQ-022 FSM states IDLE, FETCH, DECODE, EXEC, MEM_WAIT, Q_WAIT, HALT.
REQ-023 IDLE->FETCH on start; FETCH latches instr; DECODE latches both register reads; EXEC executes.
REQ-024 Opcodes: 0 LD rd<=mem[A]; 1 ST mem[B]<=A; 2 MUL; 3 ADD; 4 SUB; 5 SRL; 6 SLL; 7 AND; 8 OR; 9 XOR; 10 LDI rd<=imm; 11 CMP (flags only); 15 QPUSHI queue imm[QID_W-1:0]; 16 QPUSHR queue B[QID_W-1:0]; 17 END; all others NOP.
REQ-025 ALU results truncated to DATA_W; shift amount B modulo DATA_W; MUL keeps low DATA_W bits.
REQ-026 Flags Z (result==0) and N (result MSB) updated by opcodes 2-9 and 11 (CMP computes A-B) only.
REQ-027 Predicate: 00 always, 01 if Z, 10 if !Z, 11 if N; predicate false -> instruction is NOP, no write, no request, flags unchanged.
REQ-028 ALU/LDI/CMP/NOP: FETCH->DECODE->EXEC->FETCH, 3 cycles per instruction; rf_wen pulses one cycle in EXEC.
REQ-029 LD/ST: EXEC raises mem_req, enters MEM_WAIT; mem_req, mem_we, mem_addr, mem_wdata held stable until mem_ack; same-cycle ack permitted.
REQ-030 LD writes mem_rdata to rd in the ack cycle; ST issues no register write.
REQ-031 QPUSH: q_valid held with stable q_id/q_data=A in Q_WAIT until q_ready; dropped the cycle after handshake.
REQ-032 pc increments by 1 (wraps at 2^ADDR_W) on leaving EXEC/MEM_WAIT/Q_WAIT toward FETCH.
REQ-033 END: enter HALT, halted=1, busy=0; start in HALT restarts at start_pc, clears halted.
REQ-034 start ignored when not IDLE or HALT.

Reset
REQ-035 rst overrides everything: state=IDLE, pc=0, flags=0, rf_wen=0, mem_req=0, q_valid=0, busy=0, halted=0, all data outputs 0.
REQ-036 rst mid-MEM_WAIT or mid-Q_WAIT abandons the transaction without completing its register write.

Structure
REQ-037 Opcode, predicate and FSM state encodings live in shared package gpu_pkg.
REQ-038 Combinational ALU is sub-module gpu_alu (opcode, A, B -> result, Z, N).

Verification
REQ-039 Reset, start_pc=0x10, ADD r3=r1+r2 (5,7) -> rf_waddr=3, rf_wdata=12 on cycle 3, pc=0x11.
REQ-040 LD with mem_ack delayed 4 cycles -> mem_req/mem_addr stable 5 cycles, rd written 0xBEEF in ack cycle.
REQ-041 CMP r1,r1 then pred=10 ADD -> no rf_wen; pred=01 ADD -> written.
REQ-042 QPUSHI imm=2, q_ready low 3 cycles -> q_valid held, q_id=2, single accepted push.
REQ-043 SLL by 17 with DATA_W=16 -> shift by 1; MUL 0x100*0x100 -> 0, Z=1.
REQ-044 END -> halted=1 permanently; rst asserted during MEM_WAIT -> IDLE next cycle, mem_req=0.
